dmembus_wbc_split: RTL and testbench
====================================

# dmembus_wbc_split

Data-side memory bus controller between the CPU load/store unit and a 32-bit Wishbone controller port. It performs byte, halfword and word loads and stores at any byte address. An access that crosses a word boundary is split into two back-to-back Wishbone beats, and the read bytes are reassembled and sign- or zero-extended. Unaligned handling and a per-beat ack timeout are selected by parameters.

## Interface
- `ADDR_W`, default 32: byte-address width of `i_addr` and `wb.addr`.
- `SPLIT_UNALIGNED`, default 1:
  - 1: boundary-crossing accesses are split into two beats.
  - 0: boundary-crossing accesses are rejected with `o_unaligned`, and no bus cycle is issued.
- `TIMEOUT`, default 0: maximum cycles per beat without `ack`/`err`. 0 disables the timeout.

Ports:
- `i_clk`  in  1: the block's only clock.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `wb`  Wishbone.Controller: signals `cyc`, `stb`, `addr`, `we`, `sel[3:0]`, `data_wr[31:0]`, `data_rd[31:0]`, `ack`, `err`.
- `i_addr`  in  ADDR_W: byte address.
- `i_data`  in  32: store data, right-justified.
- `i_width`  in  2: access width. 01 = byte, 10 = half, 11 or 00 = word.
- `i_we`, `i_re`  in  1: store request, load request.
- `i_zeroextend`  in  1: load zero-extends when set; otherwise it sign-extends.
- `o_data`  out  32: load result.
- `o_stall`  out  1: access in flight.
- `o_error`  out  1: last access ended with a bus error or a timeout.
- `o_timeout`  out  1: last error was a timeout.
- `o_unaligned`  out  1: one-cycle pulse for a rejected unaligned request.
- `o_bus_width_hint`  out  2: width code of the bytes live in the current beat.

## Operation
- **Request:** `req = i_we | i_re`. A request is accepted only in IDLE. The LSU never asserts `req` while `o_stall` is 1. Behaviour is undefined if it does; the block asserts this under `VERIFICATION`.
- **Offset and size:** `off = i_addr[1:0]`; `n` = 1, 2 or 4 bytes. The access crosses a word boundary when `off + n > 4`.
- **Lane placement:** shifted data `sh = {32'b0, i_data} << (8*off)` (64 bits). Shifted enable `m = {4'b0, bytemask(n)} << off` (8 bits).
  - Beat 0: address `{i_addr[ADDR_W-1:2], 2'b00}`, `sel = m[3:0]`, `data_wr = sh[31:0]`.
  - Beat 1 (crossing accesses only): address = beat-0 address + 4, modulo 2^ADDR_W, `sel = m[7:4]`, `data_wr = sh[63:32]`.
- **`wb.cyc`:** equals `wb.stb`. `wb.cyc` drops for one cycle between beats, which releases the bus.
- **Load reassembly:** beat-0 `data_rd` is captured into the low 32 bits of a 64-bit register, and beat 1 into the high 32 bits. The result is `(reg >> 8*off)` truncated to `n` bytes, then extended per the registered zeroextend bit.
- **Rejection (`SPLIT_UNALIGNED` = 0):** a crossing request raises `o_unaligned` for one cycle. `o_stall` stays 0 and the bus is untouched.
- **FSM states:** IDLE, BEAT0, GAP, BEAT1.
  - IDLE → BEAT0 on an accepted request. `stb` rises on the next edge.
  - BEAT0 on `ack`:
    - Non-crossing access → IDLE.
    - Crossing access → GAP (`stb` = 0 for one cycle), then GAP → BEAT1.
  - BEAT1 on `ack` → IDLE.
  - BEAT0 or BEAT1 on `err` → IDLE with `o_error` = 1. There is no second beat after a beat-0 error.
  - BEAT0 or BEAT1 on timeout → IDLE with `o_error` = 1 and `o_timeout` = 1. `stb` drops, and a late `ack` is ignored.
  - `ack` and `err` in the same cycle count as `err`.
- **Timeout counter:** `$clog2(TIMEOUT+1)` bits. It clears at the start of each beat and fires when the count reaches `TIMEOUT`.
- **Error flags:** `o_error` and `o_timeout` clear when the next request is accepted.

## Timing
- **Reset values:** all outputs 0, `wb.stb` 0, `o_data` 0, FSM in IDLE.
- **Asynchronous reset mid-access:** `stb` and `o_stall` drop immediately, and the partial access is abandoned.
- **`o_stall`:** registered. It is 1 from the cycle after acceptance until the edge after the final `ack`, `err` or timeout. `o_data` is valid in the first cycle in which `o_stall` is 0.
- **Latency, zero-wait slave (`ack` in the cycle after `stb` rises):**
  - Aligned access: `o_stall` is high for 2 cycles.
  - Split access: `o_stall` is high for 5 cycles.
- **Back-to-back requests:** a new request is accepted in the cycle `o_stall` falls.
- **`o_bus_width_hint`:** updates with each beat.

## Structure
- **Package `dmembus_pkg`:**
  - width-code enum (`W_BYTE` = 01, `W_HALF` = 10, `W_WORD` = 11 / 00);
  - FSM state enum;
  - function `bytemask(width)`;
  - function `crosses(off, width)`.
- **Sub-module `dmembus_lane_align`:** combinational store shift/sel generation plus load shift/extend. The FSM, registers and timeout counter stay in the top module.

## Test plan
- **Aligned word load:** lw at 0x100, slave returns 0xDEADBEEF → one beat, `sel` 1111, `o_data` 0xDEADBEEF, `o_stall` high 2 cycles.
- **Byte loads, sign vs zero:** lb at 0x103, data_rd 0x80112233 → `sel` 1000, `o_data` 0xFFFFFF80. lbu at the same address → 0x00000080.
- **Split word store:** sw 0xAABBCCDD at 0x201 →
  - beat 0: addr 0x200, `sel` 1110, `data_wr` 0xBBCCDD00;
  - GAP cycle with `stb` 0;
  - beat 1: addr 0x204, `sel` 0001, `data_wr` 0x000000AA.
- **Split half load:** lh at 0x2FF, beat-0 data 0x12000000, beat-1 data 0x000000F3 → addrs 0x2FC then 0x300, `o_data` 0xFFFFF312.
- **Errors:**
  - Beat-0 `err` on a split access → no beat 1, `o_error` 1, `o_timeout` 0.
  - With `TIMEOUT` = 8 and a silent slave → `stb` drops after 8 cycles, `o_error` = `o_timeout` = 1, a later `ack` is ignored.
- **`SPLIT_UNALIGNED` = 0:** lw at 0x3 → `o_unaligned` pulses 1 cycle, `stb` and `o_stall` never rise.
- **Reset mid-access:** `i_rst_n` low during BEAT1 → all outputs 0 immediately; the next request runs normally.

Source files
------------

// File: rtl/dmembus_pkg.sv
// rtl/dmembus_pkg.sv - shared types and lane helpers for the data-side bus controller
package dmembus_pkg;

    typedef enum logic [1:0] {
        W_WORD_ALT = 2'b00,
        W_BYTE     = 2'b01,
        W_HALF     = 2'b10,
        W_WORD     = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BEAT0 = 2'b01,
        S_GAP   = 2'b10,
        S_BEAT1 = 2'b11
    } state_e;

    // Byte enables of an access placed at lane 0; 00 and 11 both mean a full word.
    function automatic logic [3:0] bytemask(input logic [1:0] width);
        case (width)
            W_BYTE:  return 4'b0001;
            W_HALF:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] nbytes(input logic [1:0] width);
        case (width)
            W_BYTE:  return 3'd1;
            W_HALF:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // True when the access runs past the end of its 32-bit word.
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] width);
        return ({1'b0, off} + nbytes(width)) > 3'd4;
    endfunction

    // Width code describing how many lanes a beat actually drives.
    function automatic logic [1:0] sel_width(input logic [3:0] sel);
        case ($countones(sel))
            1:       return W_BYTE;
            2:       return W_HALF;
            default: return W_WORD;
        endcase
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - 32-bit Wishbone bus bundle with controller and target views
interface Wishbone #(
    parameter int ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        sel;
    logic [31:0]       data_wr;
    logic [31:0]       data_rd;
    logic              ack;
    logic              err;

    modport Controller (
        output cyc, stb, addr, we, sel, data_wr,
        input  data_rd, ack, err
    );

    modport Target (
        input  cyc, stb, addr, we, sel, data_wr,
        output data_rd, ack, err
    );
endinterface

// File: rtl/dmembus_lane_align.sv
// rtl/dmembus_lane_align.sv - store lane placement and load extraction/extension
module dmembus_lane_align
    import dmembus_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_width,
    input  logic [31:0] st_data,
    output logic [63:0] st_lanes,
    output logic [7:0]  st_sel,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_width,
    input  logic        ld_zext,
    input  logic [63:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [63:0] ld_shifted;
    logic        ld_sign;

    // Spread store bytes across two words and pull load bytes back down to lane 0.
    always_comb begin
        st_lanes   = {32'b0, st_data} << {st_off, 3'b000};
        st_sel     = {4'b0, bytemask(st_width)} << st_off;
        ld_shifted = ld_raw >> {ld_off, 3'b000};
        ld_sign    = 1'b0;
        ld_data    = ld_shifted[31:0];
        case (ld_width)
            W_BYTE: begin
                ld_sign = ~ld_zext & ld_shifted[7];
                ld_data = {{24{ld_sign}}, ld_shifted[7:0]};
            end
            W_HALF: begin
                ld_sign = ~ld_zext & ld_shifted[15];
                ld_data = {{16{ld_sign}}, ld_shifted[15:0]};
            end
            default: ld_data = ld_shifted[31:0];
        endcase
    end

endmodule

// File: rtl/dmembus_wbc_split.sv
// rtl/dmembus_wbc_split.sv - LSU to Wishbone controller with split unaligned accesses
module dmembus_wbc_split
    import dmembus_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int SPLIT_UNALIGNED = 1,
    parameter int TIMEOUT         = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    Wishbone.Controller       wb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_data,
    input  logic [1:0]        i_width,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_zeroextend,
    output logic [31:0]       o_data,
    output logic              o_stall,
    output logic              o_error,
    output logic              o_timeout,
    output logic              o_unaligned,
    output logic [1:0]        o_bus_width_hint
);

    localparam int            TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state;
    logic              req;
    logic              cross_in;
    logic [ADDR_W-1:0] base_addr;
    logic [63:0]       st_lanes;
    logic [7:0]        st_sel;
    logic [63:0]       ld_raw;
    logic [31:0]       ld_data;

    logic              r_stb;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_data_wr;
    logic [ADDR_W-1:0] r_addr_hi;
    logic [3:0]        r_sel_hi;
    logic [31:0]       r_lanes_hi;
    logic [31:0]       r_rd_lo;
    logic [1:0]        r_off;
    logic [1:0]        r_width;
    logic              r_zext;
    logic              r_cross;
    logic [TW-1:0]     tcnt;

    assign req        = i_we | i_re;
    assign cross_in   = crosses(i_addr[1:0], i_width);
    assign base_addr  = {i_addr[ADDR_W-1:2], 2'b00};
    // Second beat holds the upper word; first beat (or an unsplit access) sits in the low word.
    assign ld_raw     = (state == S_BEAT1) ? {wb.data_rd, r_rd_lo} : {32'b0, wb.data_rd};

    assign wb.cyc     = r_stb;
    assign wb.stb     = r_stb;
    assign wb.addr    = r_addr;
    assign wb.we      = r_we;
    assign wb.sel     = r_sel;
    assign wb.data_wr = r_data_wr;

    dmembus_lane_align u_align (
        .st_off   (i_addr[1:0]),
        .st_width (i_width),
        .st_data  (i_data),
        .st_lanes (st_lanes),
        .st_sel   (st_sel),
        .ld_off   (r_off),
        .ld_width (r_width),
        .ld_zext  (r_zext),
        .ld_raw   (ld_raw),
        .ld_data  (ld_data)
    );

    // Access sequencer: accept, run one or two beats, finish on ack, err or timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            r_stb            <= 1'b0;
            r_addr           <= '0;
            r_we             <= 1'b0;
            r_sel            <= '0;
            r_data_wr        <= '0;
            r_addr_hi        <= '0;
            r_sel_hi         <= '0;
            r_lanes_hi       <= '0;
            r_rd_lo          <= '0;
            r_off            <= '0;
            r_width          <= '0;
            r_zext           <= 1'b0;
            r_cross          <= 1'b0;
            tcnt             <= '0;
            o_data           <= '0;
            o_stall          <= 1'b0;
            o_error          <= 1'b0;
            o_timeout        <= 1'b0;
            o_unaligned      <= 1'b0;
            o_bus_width_hint <= '0;
        end else begin
            o_unaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (cross_in && SPLIT_UNALIGNED == 0) begin
                            o_unaligned <= 1'b1;
                        end else begin
                            state            <= S_BEAT0;
                            r_stb            <= 1'b1;
                            o_stall          <= 1'b1;
                            o_error          <= 1'b0;
                            o_timeout        <= 1'b0;
                            tcnt             <= '0;
                            r_addr           <= base_addr;
                            r_we             <= i_we;
                            r_sel            <= st_sel[3:0];
                            r_data_wr        <= st_lanes[31:0];
                            o_bus_width_hint <= sel_width(st_sel[3:0]);
                            r_addr_hi        <= base_addr + ADDR_W'(4);
                            r_sel_hi         <= st_sel[7:4];
                            r_lanes_hi       <= st_lanes[63:32];
                            r_off            <= i_addr[1:0];
                            r_width          <= i_width;
                            r_zext           <= i_zeroextend;
                            r_cross          <= cross_in;
                        end
                    end
                end
                S_BEAT0, S_BEAT1: begin
                    if (wb.err) begin
                        state   <= S_IDLE;
                        r_stb   <= 1'b0;
                        o_stall <= 1'b0;
                        o_error <= 1'b1;
                    end else if (wb.ack) begin
                        r_stb <= 1'b0;
                        if (state == S_BEAT0 && r_cross) begin
                            state   <= S_GAP;
                            r_rd_lo <= wb.data_rd;
                        end else begin
                            state   <= S_IDLE;
                            o_stall <= 1'b0;
                            if (!r_we) begin
                                o_data <= ld_data;
                            end
                        end
                    end else if (TIMEOUT > 0 && tcnt == TO_LAST) begin
                        state     <= S_IDLE;
                        r_stb     <= 1'b0;
                        o_stall   <= 1'b0;
                        o_error   <= 1'b1;
                        o_timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_GAP: begin
                    state            <= S_BEAT1;
                    r_stb            <= 1'b1;
                    tcnt             <= '0;
                    r_addr           <= r_addr_hi;
                    r_sel            <= r_sel_hi;
                    r_data_wr        <= r_lanes_hi;
                    o_bus_width_hint <= sel_width(r_sel_hi);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef VERIFICATION
    // The LSU must hold off new requests while an access is in flight.
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(req && o_stall));
        end
    end
`endif

endmodule

// File: tb/tb_dmembus_wbc_split.sv
// tb/tb_dmembus_wbc_split.sv - self-checking bench for dmembus_wbc_split
module tb_dmembus_wbc_split;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  width = '0;
    logic        ze = 1'b0, we0 = 1'b0, re0 = 1'b0, we1 = 1'b0, re1 = 1'b0;
    logic [31:0] rdata0, rdata1;
    logic        stall0, err0, to0, un0, stall1, err1, to1, un1;
    logic [1:0]  wcode_a, wcode_b;

    Wishbone #(.ADDR_W(32)) wb0 ();
    Wishbone #(.ADDR_W(32)) wb1 ();

    dmembus_wbc_split #(.ADDR_W(32), .SPLIT_UNALIGNED(1), .TIMEOUT(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .wb(wb0), .i_addr(addr), .i_data(wdata),
        .i_width(width), .i_we(we0), .i_re(re0), .i_zeroextend(ze), .o_data(rdata0),
        .o_stall(stall0), .o_error(err0), .o_timeout(to0), .o_unaligned(un0),
        .o_bus_width_hint(wcode_a)
    );

    dmembus_wbc_split #(.ADDR_W(32), .SPLIT_UNALIGNED(0), .TIMEOUT(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .wb(wb1), .i_addr(addr), .i_data(wdata),
        .i_width(width), .i_we(we1), .i_re(re1), .i_zeroextend(ze), .o_data(rdata1),
        .o_stall(stall1), .o_error(err1), .o_timeout(to1), .o_unaligned(un1),
        .o_bus_width_hint(wcode_b)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] dw;
        logic        we;
        logic [1:0]  wcode;
    } beat_t;

    // Target model for bus 0: word memory, one-wait registered ack, optional err/silence.
    logic [31:0] smem [0:255];
    logic        s_ack = 1'b0, s_err = 1'b0, seen = 1'b0, f_ack = 1'b0;
    logic [31:0] s_rd = '0;
    int          err_beat = -1;
    bit          silent = 1'b0;
    beat_t       beats[$];

    assign wb0.ack     = s_ack | f_ack;
    assign wb0.err     = s_err;
    assign wb0.data_rd = s_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            seen  <= 1'b0;
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            if (!wb0.stb) begin
                seen <= 1'b0;
            end else if (!seen) begin
                seen <= 1'b1;
                if (!silent) begin
                    if (err_beat == beats.size()) begin
                        s_err <= 1'b1;
                    end else begin
                        s_ack <= 1'b1;
                        s_rd  <= smem[wb0.addr[9:2]];
                        if (wb0.we) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wb0.sel[b]) smem[wb0.addr[9:2]][8*b +: 8] <= wb0.data_wr[8*b +: 8];
                            end
                        end
                    end
                end
                beats.push_back('{wb0.addr, wb0.sel, wb0.data_wr, wb0.we, wcode_a});
            end
        end
    end

    // Target model for bus 1: always acks with zero data; counts any bus activity.
    logic s1_ack = 1'b0;
    int   stb1_cnt = 0;
    assign wb1.ack     = s1_ack;
    assign wb1.err     = 1'b0;
    assign wb1.data_rd = 32'h0;

    always @(posedge clk) begin
        s1_ack <= wb1.stb & ~s1_ack;
        if (wb1.stb) stb1_cnt <= stb1_cnt + 1;
    end

    // Reference byte memory mirrors what the LSU should see.
    logic [7:0] ref_mem [0:1023];
    int total = 0, bad = 0, cyc_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] w);
        case (w)
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input logic z);
        logic [31:0] v = 0;
        int n = nb(w);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) & 1023];
        if (n < 4 && !z && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        for (int i = 0; i < nb(w); i++) ref_mem[(a + i) & 1023] = d[8*i +: 8];
    endtask

    task automatic do_access(input logic w_e, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] wd, input logic z,
                             output int st, output int gaps, output int stbs);
        addr = a; wdata = d; width = wd; ze = z; we0 = w_e; re0 = ~w_e;
        @(posedge clk); #1;
        we0 = 1'b0; re0 = 1'b0;
        st = 0; gaps = 0; stbs = 0;
        while (stall0 && st < 60) begin
            st++;
            if (wb0.stb) stbs++; else gaps++;
            if (wb0.cyc !== wb0.stb) cyc_bad++;
            @(posedge clk); #1;
        end
    endtask

    task automatic access_chk(input logic w_e, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] wd, input logic z, input string tag);
        int st, gaps, stbs, exp_st;
        logic [31:0] exp_d;
        exp_st = ((a & 3) + nb(wd) > 4) ? 5 : 2;
        exp_d  = ref_load(a, wd, z);
        do_access(w_e, a, d, wd, z, st, gaps, stbs);
        chk({tag, "_stall"}, st, exp_st);
        chk({tag, "_err"}, err0, 1'b0);
        if (w_e) ref_store(a, d, wd);
        else chk({tag, "_data"}, rdata0, exp_d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int st, gaps, stbs;
        logic [31:0] a, d;
        logic [1:0] w;
        logic z, wr;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stall0, 1'b0);
        chk("rst_stb", wb0.stb, 1'b0);
        chk("rst_cyc", wb0.cyc, 1'b0);
        chk("rst_flags", {err0, to0, un0}, 3'b000);
        chk("rst_data", rdata0, 32'h0);
        chk("rst_wcode", wcode_a, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) access_chk(1'b1, i * 4, $urandom, 2'b11, 1'b0, "fill");

        access_chk(1'b1, 32'h100, 32'hDEADBEEF, 2'b11, 1'b0, "sw100");
        beats.delete();
        do_access(1'b0, 32'h100, 0, 2'b11, 1'b0, st, gaps, stbs);
        chk("lw_stall", st, 2);
        chk("lw_beats", beats.size(), 1);
        chk("lw_addr", beats[0].addr, 32'h100);
        chk("lw_sel", beats[0].sel, 4'b1111);
        chk("lw_data", rdata0, 32'hDEADBEEF);

        access_chk(1'b1, 32'h100, 32'h80112233, 2'b11, 1'b0, "sw100b");
        beats.delete();
        do_access(1'b0, 32'h103, 0, 2'b01, 1'b0, st, gaps, stbs);
        chk("lb_sel", beats[0].sel, 4'b1000);
        chk("lb_data", rdata0, 32'hFFFFFF80);
        do_access(1'b0, 32'h103, 0, 2'b01, 1'b1, st, gaps, stbs);
        chk("lbu_data", rdata0, 32'h00000080);

        beats.delete();
        do_access(1'b1, 32'h201, 32'hAABBCCDD, 2'b11, 1'b0, st, gaps, stbs);
        ref_store(32'h201, 32'hAABBCCDD, 2'b11);
        chk("sws_stall", st, 5);
        chk("sws_gap", gaps, 1);
        chk("sws_beats", beats.size(), 2);
        chk("sws_b0", {beats[0].addr, beats[0].sel, beats[0].dw, beats[0].wcode},
            {32'h200, 4'b1110, 32'hBBCCDD00, 2'b11});
        chk("sws_b1", {beats[1].addr, beats[1].sel, beats[1].dw, beats[1].wcode},
            {32'h204, 4'b0001, 32'h000000AA, 2'b01});

        access_chk(1'b1, 32'h2FC, 32'h12000000, 2'b11, 1'b0, "sw2fc");
        access_chk(1'b1, 32'h300, 32'h000000F3, 2'b11, 1'b0, "sw300");
        beats.delete();
        do_access(1'b0, 32'h2FF, 0, 2'b10, 1'b0, st, gaps, stbs);
        chk("lhs_addrs", {beats[0].addr, beats[1].addr}, {32'h2FC, 32'h300});
        chk("lhs_sels", {beats[0].sel, beats[1].sel}, {4'b1000, 4'b0001});
        chk("lhs_data", rdata0, 32'hFFFFF312);

        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 1023);
            d  = $urandom;
            w  = 2'($urandom_range(0, 3));
            z  = 1'($urandom_range(0, 1));
            access_chk(wr, a, d, w, z, $sformatf("rnd%0d", i));
        end

        err_beat = 0;
        beats.delete();
        do_access(1'b0, 32'h102, 0, 2'b11, 1'b0, st, gaps, stbs);
        err_beat = -1;
        chk("e0_stall", st, 2);
        chk("e0_beats", beats.size(), 1);
        chk("e0_flags", {err0, to0}, 2'b10);
        access_chk(1'b0, 32'h104, 0, 2'b11, 1'b0, "e0_clear");

        silent = 1'b1;
        beats.delete();
        do_access(1'b0, 32'h100, 0, 2'b11, 1'b0, st, gaps, stbs);
        silent = 1'b0;
        chk("to_stall", st, 8);
        chk("to_stbs", stbs, 8);
        chk("to_beats", beats.size(), 1);
        chk("to_flags", {err0, to0, wb0.stb}, 3'b110);
        f_ack = 1'b1;
        @(posedge clk); #1;
        f_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack", {stall0, wb0.stb, err0, to0}, 4'b0011);
        access_chk(1'b0, 32'h100, 0, 2'b11, 1'b0, "to_clear");
        chk("to_clear_flags", {err0, to0}, 2'b00);

        beats.delete();
        addr = 32'h1FD; width = 2'b11; ze = 1'b0; re0 = 1'b1;
        @(posedge clk); #1;
        re0 = 1'b0;
        for (int c = 0; c < 10 && beats.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_in_beat1", {beats.size() == 2, wb0.stb, stall0}, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus", {wb0.stb, wb0.cyc, stall0}, 3'b000);
        chk("mid_rst_flags", {err0, to0, un0, wcode_a}, 5'b0);
        chk("mid_rst_data", rdata0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        access_chk(1'b0, 32'h1FD, 0, 2'b11, 1'b1, "mid_after");
        access_chk(1'b0, 32'h3FE, 0, 2'b11, 1'b0, "wrap_load");

        chk("cyc_eq_stb", cyc_bad, 0);

        addr = 32'h3; width = 2'b11; re1 = 1'b1;
        @(posedge clk); #1;
        re1 = 1'b0;
        chk("una_pulse", {un1, stall1, wb1.stb}, 3'b100);
        @(posedge clk); #1;
        chk("una_end", {un1, stall1, wb1.stb}, 3'b000);
        chk("una_nobus", stb1_cnt, 0);
        width = 2'b01; re1 = 1'b1;
        @(posedge clk); #1;
        re1 = 1'b0;
        chk("una_byte_ok", {un1, stall1}, 2'b01);
        repeat (4) @(posedge clk);
        #1;
        chk("una_byte_done", {stall1, err1, to1}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
